// File: rtl/ysyx_22041405_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a valid/ready bus and
// holds it for decode. Redirects from execute replace the PC and squash any in-flight fetch.
module ysyx_22041405_ifu #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_imem_req_valid,
  input  logic             i_imem_req_ready,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_rsp_valid,
  output logic             o_imem_rsp_ready,
  input  logic [WIDTH-1:0] i_imem_rsp_data,
  input  logic             i_imem_rsp_err,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [WIDTH-1:0] o_inst,
  output logic [WIDTH-1:0] o_inst_pc,
  output logic             o_inst_fault
);

  localparam logic [WIDTH-1:0] NopInst = WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_drop;
  logic [WIDTH-1:0] r_inst;
  logic [WIDTH-1:0] r_inst_pc;
  logic             r_inst_fault;

  logic w_misaligned;
  logic w_req_fire;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A misaligned PC never reaches the bus; it is turned into a faulting NOP instead.
  assign w_req_fire   = (r_state == StReq) && !w_misaligned && i_imem_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_redirect_valid) r_pc <= i_redirect_pc;
          r_state <= StReq;
        end
        StReq: begin
          if (i_redirect_valid) begin
            r_pc <= i_redirect_pc;
            if (w_req_fire) begin
              r_drop  <= 1'b1;
              r_state <= StWait;
            end
          end else if (w_misaligned) begin
            r_inst       <= NopInst;
            r_inst_pc    <= r_pc;
            r_inst_fault <= 1'b1;
            r_state      <= StHold;
          end else if (w_req_fire) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          if (i_imem_rsp_valid) begin
            if (r_drop || i_redirect_valid) begin
              r_drop  <= 1'b0;
              r_state <= StReq;
            end else begin
              r_inst       <= i_imem_rsp_err ? NopInst : i_imem_rsp_data;
              r_inst_pc    <= r_pc;
              r_inst_fault <= i_imem_rsp_err;
              r_state      <= StHold;
            end
            if (i_redirect_valid) r_pc <= i_redirect_pc;
          end else if (i_redirect_valid) begin
            r_pc   <= i_redirect_pc;
            r_drop <= 1'b1;
          end
        end
        StHold: begin
          if (i_redirect_valid) begin
            r_pc    <= i_redirect_pc;
            r_state <= StReq;
          end else if (i_inst_ready) begin
            r_pc    <= r_pc + WIDTH'(4);
            r_state <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_imem_req_valid = (r_state == StReq) && !w_misaligned;
  assign o_imem_addr      = r_pc;
  assign o_imem_rsp_ready = (r_state == StWait);
  assign o_inst_valid     = (r_state == StHold);
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_inst_pc;
  assign o_inst_fault     = r_inst_fault;

endmodule
